m_mux_arb: RTL and testbench
============================

# m_mux_arb

Registered N:1 multiplexer with valid/ready handshaking on every input channel and on the output, parametrised in data width and channel count. It is the sequential successor to the combinational 16-bit 2:1 mux. It supports software-directed selection (MODE 0) and round-robin arbitration (MODE 1). It sits between multiple producers (register file read ports, ALU result, memory read data) and a single consumer bus in the CPU datapath.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- MODE, 0, 0 = explicit select via i_sel; 1 = round-robin arbitration, i_sel ignored
- SEL_W, derived = clog2(CHANNELS), width of select/channel index (not user-overridden)

Ports:
- i_clk  in  1  single clock; all state changes on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_data  in  CHANNELS*WIDTH  flattened channel data; channel k at [k*WIDTH +: WIDTH]
- i_valid  in  CHANNELS  per-channel valid
- o_ready  out  CHANNELS  per-channel ready; at most one bit high (combinational)
- i_sel  in  SEL_W  selected channel in MODE 0
- o_data  out  WIDTH  registered output data
- o_chan  out  SEL_W  index of channel that produced o_data
- o_valid  out  1  output register holds valid data
- i_ready  in  1  consumer accepts o_data this cycle

## Operation
- Output register has two states:
  - EMPTY (o_valid=0)
  - FULL (o_valid=1)
- Load enable: load_en = !o_valid | i_ready.
- Grant selection (combinational):
  - MODE 0: grant = i_sel if i_sel < CHANNELS and i_valid[i_sel]; otherwise no grant.
  - MODE 1: scan channels starting at rr_ptr, wrapping modulo CHANNELS. Grant the first k with i_valid[k]. No grant if all i_valid=0.
- o_ready[k] = load_en & (grant == k). All other o_ready bits are 0.
- Input transfer occurs on channel k when i_valid[k] & o_ready[k].
- On an input transfer at the clock edge:
  - o_data ← channel k data
  - o_chan ← k
  - o_valid ← 1
- Output transfer occurs when o_valid & i_ready.
- If an output transfer happens with no input transfer, o_valid ← 0. o_data and o_chan hold their values.
- Simultaneous output and input transfer: the register reloads and o_valid stays 1 (back-to-back, no bubble).
- FULL with i_ready=0: o_ready all 0. o_data, o_chan and o_valid hold stable until drained.
- rr_ptr (MODE 1 only):
  - On an input transfer from channel k, rr_ptr ← (k+1) mod CHANNELS.
  - Wrap: k = CHANNELS-1 gives rr_ptr ← 0.
  - rr_ptr is unchanged when there is no transfer.
- CHANNELS need not be a power of 2. Out-of-range index values are never granted.
- Reset (i_rst_n=0, asynchronous): o_valid=0, o_data=0, o_chan=0, rr_ptr=0. o_ready is forced to all 0 while reset is asserted.
- Reset mid-operation: in-flight data is discarded and not presented after reset release.

## Timing
- Input-to-output latency: 1 cycle. Data accepted at edge N appears on o_data with o_valid=1 after edge N.
- Throughput: 1 word/cycle while i_ready=1 and any valid input is grantable.
- o_ready is combinational from i_valid, i_sel, o_valid, i_ready and rr_ptr. No combinational path from i_data to any output.
- o_data, o_chan and o_valid are driven only by flops.
- Reset deassertion is taken synchronously by the integrating logic. The first transfer may occur on the first rising edge with i_rst_n=1.

## Test plan
- Reset: hold i_rst_n=0 with i_valid=4'hF and i_ready=1.
  - Required: o_valid=0, o_data=0, o_chan=0, o_ready=0.
  - Release reset in MODE 1: first grant goes to channel 0.
- MODE 0 select: WIDTH=16, ch2 data 16'hBEEF, i_valid=4'b0100, i_sel=2, i_ready=1.
  - Required: o_ready=4'b0100, then o_data=16'hBEEF, o_chan=2, o_valid=1 one cycle later.
  - With i_sel=1 instead: o_ready=0 and o_valid stays 0.
- Backpressure: FULL with o_data=16'h1234 and i_ready=0 for 3 cycles while ch0 is valid.
  - Required: o_ready=0; o_data=16'h1234 and o_valid=1 held stable.
  - When i_ready=1, ch0 loads in the same cycle the old word drains (no bubble).
- Round-robin fairness: MODE 1, i_valid=4'hF held, i_ready=1 for 8 cycles.
  - Required: o_chan sequence 0,1,2,3,0,1,2,3 (wrap at 3→0).
- Round-robin skip: MODE 1, rr_ptr=1, i_valid=4'b1001.
  - Required: grant ch3, then rr_ptr=0, then next grant ch0.
- Non-power-of-2 and async reset: CHANNELS=3, MODE 0, i_sel=3 with i_valid=3'b111.
  - Required: no grant.
  - Then assert i_rst_n=0 between clock edges while FULL: o_valid drops to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/m_mux_arb.sv
// Registered N:1 mux with valid/ready handshaking on every input channel and on the output.
// MODE 0 selects the channel named by i_sel; MODE 1 arbitrates round-robin starting at rr_ptr.
module m_mux_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]          o_chan,
  output logic                      o_valid,
  input  logic                      i_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             grant_vld;
  logic             load_en;
  logic             in_xfer;
  logic             out_xfer;
  int               scan_idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (MODE == 0) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (i_sel == SEL_W'(k) && i_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the channel closest to rr_ptr wins last.
      for (int off = CHANNELS - 1; off >= 0; off--) begin
        scan_idx = int'(rr_ptr_q) + off;
        if (scan_idx >= CHANNELS) scan_idx = scan_idx - CHANNELS;
        for (int k = 0; k < CHANNELS; k++) begin
          if (scan_idx == k && i_valid[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) grant_data = i_data[k*WIDTH +: WIDTH];
    end

    load_en  = (state_q == EMPTY) || i_ready;
    in_xfer  = grant_vld && load_en;
    out_xfer = (state_q == FULL) && i_ready;

    o_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      o_ready[k] = i_rst_n && in_xfer && (grant_idx == SEL_W'(k));
    end

    state_d  = state_q;
    data_d   = data_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
    if (in_xfer) begin
      state_d = FULL;
      data_d  = grant_data;
      chan_d  = grant_idx;
      if (MODE != 0) begin
        rr_ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign o_valid = (state_q == FULL);
  assign o_data  = data_q;
  assign o_chan  = chan_q;

endmodule

// File: tb/tb_m_mux_arb.sv
// Bench for m_mux_arb: three instances (4ch select, 4ch round-robin, 3ch select) checked
// against a queue-free behavioural model of the handshake rules, directed steps then random traffic.
module tb_m_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data4;
  logic [3:0]  valid4;
  logic [1:0]  sel4;
  logic        ready4;
  logic [47:0] data3;
  logic [2:0]  valid3;
  logic [1:0]  sel3;
  logic        ready3;

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [15:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;

  int          n_assert = 0;
  int          n_fail = 0;
  int          mv[3];
  int          mc[3];
  int          mp[3];
  logic [15:0] md[3];
  int          nch[3]  = '{4, 4, 3};
  int          mode[3] = '{0, 1, 0};

  always #5 clk = ~clk;

  m_mux_arb #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data4), .i_valid(valid4), .o_ready(rdy0),
    .i_sel(sel4), .o_data(od0), .o_chan(oc0), .o_valid(ov0), .i_ready(ready4));

  m_mux_arb #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data4), .i_valid(valid4), .o_ready(rdy1),
    .i_sel(sel4), .o_data(od1), .o_chan(oc1), .o_valid(ov1), .i_ready(ready4));

  m_mux_arb #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data3), .i_valid(valid3), .o_ready(rdy2),
    .i_sel(sel3), .o_data(od2), .o_chan(oc2), .o_valid(ov2), .i_ready(ready3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] in_valid(input int u);
    return (u < 2) ? valid4 : {1'b0, valid3};
  endfunction

  function automatic int in_sel(input int u);
    return (u < 2) ? int'(sel4) : int'(sel3);
  endfunction

  function automatic logic in_ready(input int u);
    return (u < 2) ? ready4 : ready3;
  endfunction

  function automatic logic [15:0] in_word(input int u, input int k);
    return (u < 2) ? 16'(data4 >> (16 * k)) : 16'(data3 >> (16 * k));
  endfunction

  // Channel that the spec's selection rule grants right now, or -1 for none.
  function automatic int exp_grant(input int u);
    logic [3:0] v;
    int s;
    int k;
    v = in_valid(u);
    if (mode[u] == 0) begin
      s = in_sel(u);
      if (s < nch[u] && ((v >> s) & 4'd1) != 4'd0) return s;
      return -1;
    end
    for (int off = 0; off < nch[u]; off++) begin
      k = (mp[u] + off) % nch[u];
      if (((v >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int u);
    int g;
    g = exp_grant(u);
    if (!rst_n || g < 0 || (mv[u] != 0 && !in_ready(u))) return 4'd0;
    return 4'(1) << g;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      mv[u] = 0; mc[u] = 0; mp[u] = 0; md[u] = 16'd0;
    end
  endtask

  task automatic model_edge();
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int u = 0; u < 3; u++) begin
      g = exp_grant(u);
      if (g >= 0 && (mv[u] == 0 || in_ready(u))) begin
        mv[u] = 1;
        md[u] = in_word(u, g);
        mc[u] = g;
        mp[u] = (g + 1) % nch[u];
      end else if (mv[u] != 0 && in_ready(u)) begin
        mv[u] = 0;
      end
    end
  endtask

  task automatic check_all();
    if (!rst_n) model_reset();
    chk("u0.o_valid", 64'(ov0),  64'(mv[0]));
    chk("u0.o_data",  64'(od0),  64'(md[0]));
    chk("u0.o_chan",  64'(oc0),  64'(mc[0]));
    chk("u0.o_ready", 64'(rdy0), 64'(exp_ready(0)));
    chk("u1.o_valid", 64'(ov1),  64'(mv[1]));
    chk("u1.o_data",  64'(od1),  64'(md[1]));
    chk("u1.o_chan",  64'(oc1),  64'(mc[1]));
    chk("u1.o_ready", 64'(rdy1), 64'(exp_ready(1)));
    chk("u2.o_valid", 64'(ov2),  64'(mv[2]));
    chk("u2.o_data",  64'(od2),  64'(md[2]));
    chk("u2.o_chan",  64'(oc2),  64'(mc[2]));
    chk("u2.o_ready", 64'(rdy2), 64'(exp_ready(2)));
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    data4  = 64'h4444_3333_2222_1111;
    valid4 = 4'hF;
    sel4   = 2'd0;
    ready4 = 1'b1;
    data3  = 48'hC3C3_B2B2_A1A1;
    valid3 = 3'b111;
    sel3   = 2'd3;
    ready3 = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset held with every channel valid
    cycle();
    cycle();
    chk("rst_ready1", 64'(rdy1), 64'h0);
    chk("rst_valid1", 64'(ov1), 64'h0);

    // Release: round-robin starts at channel 0
    rst_n = 1'b1;
    #1;
    chk("rr_first_grant", 64'(rdy1), 64'h1);
    cycle();

    // Select mode: channel 2 carries BEEF
    data4  = 64'h4444_BEEF_2222_1111;
    valid4 = 4'b0100;
    sel4   = 2'd2;
    #1;
    chk("sel_ready", 64'(rdy0), 64'h4);
    cycle();
    chk("sel_data", 64'(od0), 64'hBEEF);
    chk("sel_chan", 64'(oc0), 64'h2);
    chk("sel_valid", 64'(ov0), 64'h1);
    sel4 = 2'd1;
    #1;
    chk("sel_miss_ready", 64'(rdy0), 64'h0);
    cycle();
    chk("sel_miss_valid", 64'(ov0), 64'h0);

    // Backpressure: hold 1234 while channel 0 offers 5678
    valid4 = 4'b0001;
    sel4   = 2'd0;
    data4  = 64'h4444_3333_2222_1234;
    cycle();
    ready4 = 1'b0;
    data4  = 64'h4444_3333_2222_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(rdy0), 64'h0);
      chk("bp_data", 64'(od0), 64'h1234);
      chk("bp_valid", 64'(ov0), 64'h1);
      cycle();
    end
    ready4 = 1'b1;
    #1;
    chk("bp_release_ready", 64'(rdy0), 64'h1);
    cycle();
    chk("bp_no_bubble_data", 64'(od0), 64'h5678);
    chk("bp_no_bubble_valid", 64'(ov0), 64'h1);

    // Mid-operation reset, then round-robin fairness
    rst_n = 1'b0;
    cycle();
    rst_n  = 1'b1;
    valid4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_seq", 64'(oc1), 64'(i % 4));
      chk("rr_valid", 64'(ov1), 64'h1);
    end

    // Round-robin skip from pointer 1 over idle channels
    valid4 = 4'b0001;
    cycle();
    chk("rr_skip_setup", 64'(oc1), 64'h0);
    valid4 = 4'b1001;
    cycle();
    chk("rr_skip_ch3", 64'(oc1), 64'h3);
    cycle();
    chk("rr_skip_wrap_ch0", 64'(oc1), 64'h0);

    // Three channels: index 3 is out of range and never granted
    #1;
    chk("oor_ready", 64'(rdy2), 64'h0);
    chk("oor_valid", 64'(ov2), 64'h0);
    sel3  = 2'd1;
    data3 = 48'hC3C3_ABCD_A1A1;
    cycle();
    chk("c3_data", 64'(od2), 64'hABCD);
    chk("c3_valid", 64'(ov2), 64'h1);
    ready3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid2", 64'(ov2), 64'h0);
    chk("async_rst_data2", 64'(od2), 64'h0);
    chk("async_rst_valid1", 64'(ov1), 64'h0);
    model_reset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      data4  = {$urandom, $urandom};
      valid4 = 4'($urandom);
      sel4   = 2'($urandom);
      ready4 = ($urandom % 4) != 0;
      data3  = {16'($urandom), $urandom};
      valid3 = 3'($urandom);
      sel3   = 2'($urandom_range(0, 3));
      ready3 = ($urandom % 3) != 0;
      rst_n  = ($urandom % 50) != 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
